router_pkt_tx: RTL and testbench

Packet transmitter for the 1x3 router's source port. It accepts a packet request (destination address, payload length) and the payload bytes from a local producer, and buffers the whole payload. It then drives the router input with a gap-free header/payload burst followed by the parity byte, honouring the router's `busy` stall. Afterwards it watches the router's `err` for a short window and reports completion.

---
 rtl/router_pkt_tx.sv | 204 ++++++++++++++++++++
 tb/tb_router_pkt_tx.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/router_pkt_tx.sv
// router_pkt_tx - packet transmitter for the router's source port.
//
// Accepts a request (addr, len), buffers the whole payload from the local
// producer, then sends a gap-free header/payload burst followed by the
// parity byte, honouring the router's busy stall. Afterwards it watches
// err for ERR_WIN cycles and reports completion with pkt_done/pkt_err.
//
// Ports:
//   clock, resetn          clock and synchronous active-low reset
//   req_valid/req_ready    request handshake; req_addr, req_len, par_inj
//                          are latched on accept
//   pl_valid/pl_ready      payload byte handshake, pl_data
//   busy, err              router stall and parity-error indication
//   pkt_valid, data_out    byte stream to the router
//   pkt_done, pkt_err      end-of-packet pulse and its error flag
//
// Build option: define ROUTER_TX_PAR_INJ_EN to let par_inj (sampled at
// request accept) invert that packet's parity byte. Without it par_inj
// is ignored and parity is always correct.
module router_pkt_tx #(
    parameter int MAX_LEN = 63,
    parameter int ERR_WIN = 3
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_addr,
    input  logic [5:0] req_len,
    input  logic       pl_valid,
    output logic       pl_ready,
    input  logic [7:0] pl_data,
    input  logic       par_inj,
    input  logic       busy,
    input  logic       err,
    output logic       pkt_valid,
    output logic [7:0] data_out,
    output logic       pkt_done,
    output logic       pkt_err
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_HEADER  = 3'd2;
    localparam logic [2:0] S_PAYLOAD = 3'd3;
    localparam logic [2:0] S_PARITY  = 3'd4;
    localparam logic [2:0] S_CHECK   = 3'd5;

    localparam int            EW        = $clog2(ERR_WIN + 1);
    localparam logic [EW-1:0] ECNT_LAST = EW'(ERR_WIN);

    logic [2:0]    state_q,  state_d;
    logic [1:0]    addr_q,   addr_d;
    logic [5:0]    len_q,    len_d;
    logic          inj_q,    inj_d;
    logic [5:0]    wcnt_q,   wcnt_d;
    logic [5:0]    rcnt_q,   rcnt_d;
    logic [7:0]    par_q,    par_d;
    logic [EW-1:0] ecnt_q,   ecnt_d;
    logic          sticky_q, sticky_d;

    logic [7:0] buf_mem [0:MAX_LEN-1];
    logic [7:0] rd_data_q;
    logic       wr_en;
    logic [5:0] len_in;
    logic       inj_in;
    logic [7:0] hdr_byte;

    // Oversize lengths only exist when the buffer is shallower than the
    // 6-bit length field can express.
    if (MAX_LEN < 63) begin : g_clamp
        assign len_in = (req_len > 6'(MAX_LEN)) ? 6'(MAX_LEN) : req_len;
    end else begin : g_noclamp
        assign len_in = req_len;
    end

`ifdef ROUTER_TX_PAR_INJ_EN
    assign inj_in = par_inj;
`else
    logic unused_par_inj;
    assign unused_par_inj = par_inj;
    assign inj_in         = 1'b0;
`endif

    assign hdr_byte = {len_q, addr_q};
    assign wr_en    = (state_q == S_LOAD) && pl_valid;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        len_d    = len_q;
        inj_d    = inj_q;
        wcnt_d   = wcnt_q;
        rcnt_d   = rcnt_q;
        par_d    = par_q;
        ecnt_d   = ecnt_q;
        sticky_d = sticky_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    len_d   = len_in;
                    inj_d   = inj_in;
                    wcnt_d  = 6'd0;
                    rcnt_d  = 6'd0;
                    state_d = (len_in == 6'd0) ? S_HEADER : S_LOAD;
                end
            end
            S_LOAD: begin
                if (pl_valid) begin
                    wcnt_d = wcnt_q + 6'd1;
                    if (wcnt_q == len_q - 6'd1) begin
                        state_d = S_HEADER;
                    end
                end
            end
            S_HEADER: begin
                if (!busy) begin
                    par_d   = hdr_byte;
                    state_d = (len_q == 6'd0) ? S_PARITY : S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (!busy) begin
                    par_d  = par_q ^ rd_data_q;
                    rcnt_d = rcnt_q + 6'd1;
                    if (rcnt_q == len_q - 6'd1) begin
                        state_d = S_PARITY;
                    end
                end
            end
            S_PARITY: begin
                if (!busy) begin
                    // err seen alongside the parity transfer is ignored;
                    // the window opens in CHECK.
                    ecnt_d   = '0;
                    sticky_d = 1'b0;
                    state_d  = S_CHECK;
                end
            end
            S_CHECK: begin
                // ERR_WIN sampling cycles, then one extra cycle that
                // presents pkt_done/pkt_err from registered state.
                if (ecnt_q == ECNT_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    ecnt_d   = ecnt_q + EW'(1);
                    sticky_d = sticky_q | err;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            addr_q   <= 2'd0;
            len_q    <= 6'd0;
            inj_q    <= 1'b0;
            wcnt_q   <= 6'd0;
            rcnt_q   <= 6'd0;
            par_q    <= 8'd0;
            ecnt_q   <= '0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            inj_q    <= inj_d;
            wcnt_q   <= wcnt_d;
            rcnt_q   <= rcnt_d;
            par_q    <= par_d;
            ecnt_q   <= ecnt_d;
            sticky_q <= sticky_d;
        end
    end

    // Payload buffer with registered read. The read address is the next
    // read count, so rd_data_q already holds buf[rcnt] when PAYLOAD shows
    // it, and a stall simply re-reads the same entry.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            buf_mem[wcnt_q] <= pl_data;
        end
        rd_data_q <= buf_mem[rcnt_d];
    end

    assign req_ready = resetn && (state_q == S_IDLE);
    assign pl_ready  = (state_q == S_LOAD);
    assign pkt_valid = (state_q == S_HEADER) || (state_q == S_PAYLOAD);
    assign pkt_done  = (state_q == S_CHECK) && (ecnt_q == ECNT_LAST);
    assign pkt_err   = pkt_done && sticky_q;

    always_comb begin
        case (state_q)
            S_HEADER:  data_out = hdr_byte;
            S_PAYLOAD: data_out = rd_data_q;
            S_PARITY:  data_out = par_q ^ {8{inj_q}};
            default:   data_out = 8'd0;
        endcase
    end

endmodule

// File: tb/tb_router_pkt_tx.sv
// tb_router_pkt_tx - self-checking bench for router_pkt_tx.
// Directed packets from the test plan plus randomized packets (length,
// payload, busy stalls, payload gaps, err activity) checked against a
// transaction-level model: expected byte list and parity are computed
// from the packet contents, and the err window is modelled as a count of
// cycles after the parity transfer.
module tb_router_pkt_tx;

    localparam int MAX_LEN = 63;
    localparam int ERR_WIN = 3;

    logic       clk;
    logic       resetn;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_addr;
    logic [5:0] req_len;
    logic       pl_valid;
    logic       pl_ready;
    logic [7:0] pl_data;
    logic       par_inj;
    logic       busy;
    logic       err;
    logic       pkt_valid;
    logic [7:0] data_out;
    logic       pkt_done;
    logic       pkt_err;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] pl_buf [0:63];

    router_pkt_tx #(.MAX_LEN(MAX_LEN), .ERR_WIN(ERR_WIN)) dut (
        .clock     (clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .pl_valid  (pl_valid),
        .pl_ready  (pl_ready),
        .pl_data   (pl_data),
        .par_inj   (par_inj),
        .busy      (busy),
        .err       (err),
        .pkt_valid (pkt_valid),
        .data_out  (data_out),
        .pkt_done  (pkt_done),
        .pkt_err   (pkt_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One packet end to end. hold_idx: byte index held with busy for two
    // cycles (-1 none). abort_idx: byte index at which resetn is pulsed
    // (-1 none). err_force: pulse err in the first window cycle.
    task automatic run_pkt(input logic [1:0] addr, input int len, input bit inj,
                           input int busy_pct, input int gap_pct, input int hold_idx,
                           input int abort_idx, input bit err_force);
        logic [7:0]  exp_q [$];
        logic [7:0]  par;
        logic [10:0] exp_out;
        bit          sticky;
        bit          accepted;
        int          sent, idx, cyc, hold_left;

        // Reference model: header {len,addr}, payload, XOR parity.
        par = {len[5:0], addr};
        exp_q.push_back(par);
        for (int i = 0; i < len; i++) begin
            exp_q.push_back(pl_buf[i]);
            par = par ^ pl_buf[i];
        end
`ifdef ROUTER_TX_PAR_INJ_EN
        if (inj) par = ~par;
`endif
        exp_q.push_back(par);

        cyc = 0;
        while (!req_ready && cyc < 50) begin
            tick;
            cyc++;
        end
        check_eq("req_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_addr  = addr;
        req_len   = len[5:0];
        par_inj   = inj;
        tick;
        req_valid = 1'b0;
        req_addr  = 2'($urandom);
        req_len   = 6'($urandom);
        par_inj   = 1'($urandom);
        check_eq("req_ready_low", 32'(req_ready), 32'd0);

        sent = 0;
        cyc  = 0;
        while (sent < len && cyc < 4000) begin
            check_eq("load", 32'({pkt_valid, pl_ready}), 32'd1);
            pl_valid = ($urandom_range(99) >= gap_pct);
            pl_data  = pl_valid ? pl_buf[sent] : 8'($urandom);
            accepted = pl_valid && pl_ready;
            tick;
            if (accepted) sent++;
            cyc++;
        end
        pl_valid = 1'b0;
        if (sent < len) check_eq("load_timeout", 32'(sent), 32'(len));

        idx       = 0;
        cyc       = 0;
        hold_left = 2;
        while (idx < len + 2 && cyc < 8000) begin
            if (abort_idx >= 0 && idx == abort_idx) begin
                resetn = 1'b0;
                busy   = 1'b0;
                err    = 1'b0;
                tick;
                check_eq("abort", 32'({req_ready, pl_ready, pkt_valid, pkt_done, pkt_err, data_out}), 32'd0);
                resetn = 1'b1;
                tick;
                check_eq("abort_rel", 32'({req_ready, pkt_valid, pkt_done}), 32'b100);
                $display("pkt addr=%0d len=%0d aborted at byte %0d", addr, len, abort_idx);
                return;
            end
            exp_out = {(idx <= len), 1'b0, 1'b0, exp_q[idx]};
            check_eq("out", 32'({pkt_valid, pl_ready, pkt_done, data_out}), 32'(exp_out));
            if (idx == hold_idx && hold_left > 0) begin
                busy = 1'b1;
                hold_left--;
            end else begin
                busy = ($urandom_range(99) < busy_pct);
            end
            // err while the parity byte is on the bus must not count
            err = (idx == len + 1) ? 1'b1 : 1'($urandom);
            tick;
            if (!busy) idx++;
            cyc++;
        end
        busy = 1'b0;
        if (idx < len + 2) check_eq("out_timeout", 32'(idx), 32'(len + 2));

        sticky = 1'b0;
        for (int k = 0; k < ERR_WIN; k++) begin
            check_eq("window", 32'({pkt_valid, pkt_done, req_ready, data_out}), 32'd0);
            err    = (err_force && k == 0) ? 1'b1 : ($urandom_range(3) == 0);
            sticky = sticky | err;
            tick;
        end
        check_eq("done", 32'({pkt_done, pkt_err, req_ready}), 32'({1'b1, sticky, 1'b0}));
        err = 1'($urandom);
        tick;
        err = 1'b0;
        check_eq("idle", 32'({pkt_done, pkt_err, req_ready}), 32'b001);
        $display("pkt addr=%0d len=%0d inj=%0b parity=%02h pkt_err=%0b", addr, len, inj, par, sticky);
    endtask

    initial begin
        resetn    = 1'b0;
        req_valid = 1'b0;
        req_addr  = 2'd0;
        req_len   = 6'd0;
        pl_valid  = 1'b0;
        pl_data   = 8'd0;
        par_inj   = 1'b0;
        busy      = 1'b0;
        err       = 1'b0;
        repeat (3) tick;
        check_eq("reset", 32'({req_ready, pl_ready, pkt_valid, pkt_done, pkt_err, data_out}), 32'd0);
        resetn = 1'b1;
        tick;
        check_eq("reset_rel", 32'(req_ready), 32'd1);

        pl_buf[0] = 8'h11; pl_buf[1] = 8'h22; pl_buf[2] = 8'h33;
        run_pkt(2'd1, 3, 1'b0, 0, 0, -1, -1, 1'b0);
        run_pkt(2'd1, 3, 1'b0, 0, 0, 2, -1, 1'b0);
        run_pkt(2'd2, 0, 1'b0, 0, 0, -1, -1, 1'b0);
        pl_buf[0] = 8'hA5;
        run_pkt(2'd0, 1, 1'b1, 0, 0, -1, -1, 1'b1);
        for (int i = 0; i < 5; i++) pl_buf[i] = 8'($urandom);
        run_pkt(2'd3, 5, 1'b0, 0, 0, -1, 3, 1'b0);
        pl_buf[0] = 8'h5A; pl_buf[1] = 8'hC3;
        run_pkt(2'd3, 2, 1'b0, 0, 0, -1, -1, 1'b0);
        for (int i = 0; i < 4; i++) pl_buf[i] = 8'($urandom);
        run_pkt(2'd2, 4, 1'b0, 0, 50, -1, -1, 1'b0);
        for (int i = 0; i < MAX_LEN; i++) pl_buf[i] = 8'($urandom);
        run_pkt(2'd1, MAX_LEN, 1'b1, 20, 20, -1, -1, 1'b0);

        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < MAX_LEN; i++) pl_buf[i] = 8'($urandom);
            run_pkt(2'($urandom), $urandom_range(MAX_LEN), 1'($urandom),
                    $urandom_range(50), $urandom_range(50), -1, -1, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
